// File: rtl/lms_ctrl_pkg.sv
// lms_ctrl_pkg: shared types and constants for the LMS tap sequencer.
//   state_t     : sequencer FSM states
//   ORDER_DEF   : default tap count
//   RD_LAT      : x/w RAM read latency in cycles
//   UPD_WB_LAT  : cycles from coefficient read to its write-back
//   addr_w_for  : address width needed to index ORDER taps
package lms_ctrl_pkg;

  localparam int ORDER_DEF  = 80;
  localparam int RD_LAT     = 1;
  localparam int UPD_WB_LAT = 2;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    FILT,
    DRAIN,
    ERR,
    UPD,
    UDRAIN,
    DONE
  } state_t;

  function automatic int addr_w_for(input int order);
    return (order <= 2) ? 1 : $clog2(order);
  endfunction

endpackage

// File: rtl/lms_ring_addr.sv
// lms_ring_addr: circular delay-line addressing.
//   clk, rst : clock, synchronous active-high reset (head -> 0)
//   dec      : step head back one slot, wrapping 0 -> ORDER-1
//   clr      : force head to 0 (after the zero-fill pass)
//   base, k  : operands of the modular sum
//   head     : current write slot of the delay line
//   sum      : (base + k) mod ORDER, both operands already < ORDER
module lms_ring_addr #(
  parameter int ORDER  = 80,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec,
  input  logic              clr,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] k,
  output logic [ADDR_W-1:0] head,
  output logic [ADDR_W-1:0] sum
);

  localparam int              AW1   = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(ORDER - 1);
  localparam logic [AW1-1:0]    ORD_W = AW1'(ORDER);

  logic [AW1-1:0] raw;
  logic [AW1-1:0] wrapped;

  always_ff @(posedge clk) begin
    if (rst)      head <= '0;
    else if (clr) head <= '0;
    else if (dec) head <= (head == '0) ? LAST : head - ADDR_W'(1);
  end

  // Both operands are below ORDER, so one conditional subtract suffices.
  assign raw     = {1'b0, base} + {1'b0, k};
  assign wrapped = raw - ORD_W;
  assign sum     = (raw >= ORD_W) ? wrapped[ADDR_W-1:0] : raw[ADDR_W-1:0];

endmodule

// File: rtl/lms_tap_sequencer.sv
// lms_tap_sequencer: control FSM for a time-multiplexed LMS noise canceller.
// Drives addresses/enables for the x (delay-line) RAM, w (coefficient) RAM
// and a shared MAC; performs no arithmetic on samples itself.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : sample handshake (ready only while idle)
//   adapt_en              : captured at accept; 0 skips the coefficient pass
//   coef_init             : zero-fill both RAMs (idle only, beats in_valid)
//   ovr_clr               : clears the sticky overrun flag
//   x_wr_en/x_zero/x_addr : delay-line write/read port controls
//   w_rd_addr             : coefficient read address
//   w_wr_en/w_zero/w_wr_addr : coefficient write port controls
//   mac_en/mac_clr        : accumulate / load the current product
//   err_latch             : datapath captures e = d - y
//   out_valid             : one-cycle pulse, sample fully processed
//   busy, overrun         : status
module lms_tap_sequencer
  import lms_ctrl_pkg::*;
#(
  parameter int ORDER  = ORDER_DEF,
  parameter int ADDR_W = addr_w_for(ORDER)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              adapt_en,
  input  logic              coef_init,
  input  logic              ovr_clr,
  output logic              x_wr_en,
  output logic              x_zero,
  output logic [ADDR_W-1:0] x_addr,
  output logic [ADDR_W-1:0] w_rd_addr,
  output logic              w_wr_en,
  output logic              w_zero,
  output logic [ADDR_W-1:0] w_wr_addr,
  output logic              mac_en,
  output logic              mac_clr,
  output logic              err_latch,
  output logic              out_valid,
  output logic              busy,
  output logic              overrun
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ORDER - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] k, k_nxt;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] head;
  logic [ADDR_W-1:0] ring_sum;
  logic              adapt_q;
  logic              accept;
  logic              init_go;
  logic              head_clr;
  logic              k_last;
  logic              filt_rd;
  logic              upd_rd;

  // Read-issue and write-back pipelines; index i = issued i cycles ago.
  logic [RD_LAT:1]                  mac_vld_pipe;
  logic [RD_LAT:1]                  mac_clr_pipe;
  logic [UPD_WB_LAT:1]              wb_vld_pipe;
  logic [UPD_WB_LAT:1][ADDR_W-1:0]  wb_addr_pipe;

  assign in_ready = (state == IDLE) && !rst;
  assign init_go  = in_ready && coef_init;
  assign accept   = in_ready && in_valid && !coef_init;
  assign k_last   = (k == LAST);
  assign filt_rd  = (state == FILT);
  assign upd_rd   = (state == UPD);

  lms_ring_addr #(
    .ORDER  (ORDER),
    .ADDR_W (ADDR_W)
  ) u_ring (
    .clk  (clk),
    .rst  (rst),
    .dec  (accept),
    .clr  (head_clr),
    .base (base),
    .k    (k),
    .head (head),
    .sum  (ring_sum)
  );

  // k is the tap index in INIT/FILT/UPD and a small cycle counter in the
  // drain states.
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    head_clr  = 1'b0;
    unique case (state)
      IDLE: begin
        if (init_go) begin
          state_nxt = INIT;
          k_nxt     = '0;
        end else if (accept) begin
          state_nxt = FILT;
          k_nxt     = '0;
        end
      end
      INIT: begin
        if (k_last) begin
          state_nxt = IDLE;
          k_nxt     = '0;
          head_clr  = 1'b1;
        end else begin
          k_nxt = k + ADDR_W'(1);
        end
      end
      FILT: begin
        if (k_last) begin
          state_nxt = DRAIN;
          k_nxt     = '0;
        end else begin
          k_nxt = k + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (k == ADDR_W'(RD_LAT - 1)) begin
          state_nxt = ERR;
          k_nxt     = '0;
        end else begin
          k_nxt = k + ADDR_W'(1);
        end
      end
      ERR: begin
        state_nxt = adapt_q ? UPD : DONE;
        k_nxt     = '0;
      end
      UPD: begin
        if (k_last) begin
          state_nxt = UDRAIN;
          k_nxt     = '0;
        end else begin
          k_nxt = k + ADDR_W'(1);
        end
      end
      UDRAIN: begin
        if (k == ADDR_W'(UPD_WB_LAT - 1)) begin
          state_nxt = DONE;
          k_nxt     = '0;
        end else begin
          k_nxt = k + ADDR_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
        k_nxt     = '0;
      end
      default: begin
        state_nxt = IDLE;
        k_nxt     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      k            <= '0;
      base         <= '0;
      adapt_q      <= 1'b0;
      overrun      <= 1'b0;
      mac_vld_pipe <= '0;
      mac_clr_pipe <= '0;
      wb_vld_pipe  <= '0;
      wb_addr_pipe <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      if (accept) begin
        base    <= head;
        adapt_q <= adapt_en;
      end
      // Set has priority over clear so a drop coinciding with a clear is
      // never lost.
      if (in_valid && !in_ready) overrun <= 1'b1;
      else if (ovr_clr)          overrun <= 1'b0;

      mac_vld_pipe[1] <= filt_rd;
      mac_clr_pipe[1] <= filt_rd && (k == '0);
      for (int i = 2; i <= RD_LAT; i++) begin
        mac_vld_pipe[i] <= mac_vld_pipe[i-1];
        mac_clr_pipe[i] <= mac_clr_pipe[i-1];
      end

      wb_vld_pipe[1]  <= upd_rd;
      wb_addr_pipe[1] <= k;
      for (int i = 2; i <= UPD_WB_LAT; i++) begin
        wb_vld_pipe[i]  <= wb_vld_pipe[i-1];
        wb_addr_pipe[i] <= wb_addr_pipe[i-1];
      end
    end
  end

  always_comb begin
    x_wr_en   = accept || (state == INIT);
    x_zero    = (state == INIT);
    w_zero    = (state == INIT);
    w_wr_en   = (state == INIT) || wb_vld_pipe[UPD_WB_LAT];
    w_wr_addr = '0;
    if (state == INIT)                 w_wr_addr = k;
    else if (wb_vld_pipe[UPD_WB_LAT])  w_wr_addr = wb_addr_pipe[UPD_WB_LAT];
    x_addr    = '0;
    w_rd_addr = '0;
    case (state)
      IDLE:     x_addr = head;
      INIT:     x_addr = k;
      FILT, UPD: begin
        x_addr    = ring_sum;
        w_rd_addr = k;
      end
      default: ;
    endcase
    mac_en    = mac_vld_pipe[RD_LAT];
    mac_clr   = mac_clr_pipe[RD_LAT];
    err_latch = (state == ERR);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

endmodule
